// File: rtl/rotate_iter_engine_if.sv
// Request/result handshake bundle for the sequential rotate engine.
// The engine side uses the slave modport and the requester/consumer side uses master.
interface rotate_iter_engine_if #(
    parameter int WIDTH = 8
) ();
    localparam int AW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rotate_iter_engine.sv
// Multi-cycle bit rotator: rotates the captured word one position per clock,
// then holds the result until the consumer takes it.
module rotate_iter_engine #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rotate_iter_engine_if.slave   bus,
    output logic                  busy
);
    localparam int AW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    count_q, count_d;
    logic             dir_q, dir_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    // The count reaching zero costs one extra cycle to enter DONE, so latency is amt+1.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    count_d = bus.in_amt;
                    dir_d   = bus.in_dir;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q != '0) begin
                    if (dir_q) begin
                        data_d = {data_q[0], data_q[WIDTH-1:1]};
                    end else begin
                        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    end
                    count_d = count_q - AW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign busy          = (state_q == BUSY) || (state_q == DONE);
endmodule

// File: tb/tb_rotate_iter_engine.sv
// Scoreboard bench for rotate_iter_engine: stimulus pushes expected results,
// an independent monitor checks result values, latency and hold stability.
module tb_rotate_iter_engine;
    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    rotate_iter_engine_if #(.WIDTH(WIDTH)) bus ();

    rotate_iter_engine #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               amt;
        int               accept_cycle;
    } exp_t;

    exp_t             sb[$];
    int               n_vec      = 0;
    int               n_fail     = 0;
    int               cycle      = 0;
    int               ready_mode = 0;
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] held_data  = '0;

    always @(posedge clk) cycle++;

    // Consumer side: out_ready changes just after each edge so the monitor sees it settled.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [WIDTH-1:0] rot_ref(input logic [WIDTH-1:0] d, input int amt, input logic dir);
        longint unsigned x = 64'(d);
        longint unsigned r;
        if (!dir) r = (x << amt) | (x >> (WIDTH - amt));
        else      r = (x >> amt) | (x << (WIDTH - amt));
        return r[WIDTH-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_vec++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_result: got out_data 0x%0h, expected no result", bus.out_data);
                end else begin
                    checkOutput("latency", 32'(cycle - sb[0].accept_cycle), 32'(sb[0].amt + 1));
                end
                held_data = bus.out_data;
            end else if (bus.out_valid) begin
                checkOutput("hold_stable", 32'(bus.out_data), 32'(held_data));
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("result", 32'(bus.out_data), 32'(e.data));
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input int amt, input logic dir,
                                 input logic [WIDTH-1:0] exp_data);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            reportTimeout("accept");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = AW'(amt);
        bus.in_dir   = dir;
        e.data         = exp_data;
        e.amt          = amt;
        e.accept_cycle = cycle + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !bus.in_ready) reportTimeout("drain");
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_busy"},      32'(busy),          32'd0);
        checkOutput({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        int               ra;
        logic             rdir;
        int               n;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b1;

        #2;
        checkIdleOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        applyStimulus(8'b0110_0010, 3, 1'b0, 8'b0001_0011);
        applyStimulus(8'b0110_0010, 3, 1'b1, 8'b0100_1100);
        applyStimulus(8'b0110_0010, 0, 1'b0, 8'b0110_0010);
        applyStimulus(8'b0110_0010, 7, 1'b0, 8'b0011_0001);
        applyStimulus(8'b0110_0010, 1, 1'b1, 8'b0011_0001);
        applyStimulus(8'b1000_0001, 7, 1'b1, 8'b0000_0011);
        waitDrain();

        // Backpressure: the result must hold and a new request must not slip in.
        ready_mode = 1;
        applyStimulus(8'b1000_0001, 2, 1'b0, 8'b0000_0110);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) reportTimeout("bp_out_valid");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_amt   = AW'(1);
        bus.in_dir   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready",  32'(bus.in_ready),  32'd0);
            checkOutput("bp_busy",      32'(busy),          32'd1);
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        ready_mode   = 0;
        n = 0;
        while (bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_release_busy",     32'(busy),         32'd0);
        checkOutput("bp_sb_empty",         32'(sb.size()),    32'd0);

        // Reset in the middle of a rotation discards the request.
        applyStimulus(8'h3C, 6, 1'b0, rot_ref(8'h3C, 6, 1'b0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("no_result_after_reset", 32'(bus.out_valid), 32'd0);
        applyStimulus(8'hA5, 1, 1'b1, 8'b1101_0010);
        waitDrain();

        // Random sweep with random consumer stalls, checked against the arithmetic formula.
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            rd   = WIDTH'($urandom);
            ra   = int'($urandom_range(0, WIDTH - 1));
            rdir = 1'($urandom_range(0, 1));
            applyStimulus(rd, ra, rdir, rot_ref(rd, ra, rdir));
        end
        waitDrain();
        ready_mode = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
